// File: rtl/atm_disp_pkg.sv
// Shared constants and the 7-segment pattern table for the ATM display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low (common-anode).
package atm_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  // Entry n is the pattern for decimal digit n (entry 0 is the rightmost field).
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/atm_display_scanner_bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// 0-9 are digits, DIG_DASH is a dash, and every other code is blank.
module bcd_to_seg
  import atm_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (digit_i <= 4'd9)          seg_o = SEG_TABLE[digit_i];
    else if (digit_i == DIG_DASH) seg_o = SEG_DASH;
  end

endmodule

// File: rtl/atm_display_scanner.sv
// Double-buffered, time-multiplexed 7-segment scanner for the ATM display.
// Optional leading-zero blanking: define ATM_DISP_LEAD_ZERO_BLANK_EN.
module atm_display_scanner
  import atm_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   dataIn,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int DW = 4*DIGITS;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic [DW-1:0]     pbuf_q, pbuf_d;
  logic              pend_q, pend_d;
  logic              fd_q;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic              cnt_tc, idx_last, boundary;
  logic [3:0]        nib, nib_eff;

  assign cnt_tc   = (cnt_q == CW'(REFRESH_DIV-1));
  assign idx_last = (idx_q == IW'(DIGITS-1));
  assign boundary = cnt_tc & idx_last;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    idx_d  = idx_q;
    disp_d = disp_q;
    pbuf_d = pbuf_q;
    pend_d = pend_q;
    if (cnt_tc) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + IW'(1);
    end
    // A load on the boundary cycle bypasses the pending buffer entirely.
    if (boundary) begin
      if (en)          disp_d = dataIn;
      else if (pend_q) disp_d = pbuf_q;
      pend_d = 1'b0;
    end else if (en) begin
      pbuf_d = dataIn;
      pend_d = 1'b1;
    end
  end

  assign nib = disp_q[4*idx_q +: 4];

`ifdef ATM_DISP_LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_mask;
  logic              seen_nz;

  // Walk from the top digit down; zeros above the first non-zero are blanked.
  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS-1; i >= 1; i--) begin
      if (disp_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      lz_mask[i] = ~seen_nz;
    end
  end

  assign nib_eff = lz_mask[idx_q] ? DIG_BLANK : nib;
`else
  assign nib_eff = nib;
`endif

  bcd_to_seg u_dec (
    .digit_i (nib_eff),
    .seg_o   (seg_d)
  );

  assign an_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      pbuf_q <= '0;
      pend_q <= 1'b0;
      fd_q   <= 1'b0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      pbuf_q <= pbuf_d;
      pend_q <= pend_d;
      fd_q   <= boundary;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_atm_display_scanner.sv
// Directed self-checking bench for atm_display_scanner (DIGITS=4, REFRESH_DIV=4).
// Every post-reset cycle checks an, seg and frame_done against hand-derived expectations.
module tb_atm_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] dataIn = 16'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic        pending;

  int checks = 0;
  int errors = 0;
  int k = 0;                       // clock edges since reset release
  logic [15:0] shown = 16'h0;      // word currently on the display
  logic [15:0] next_shown = 16'h0; // word to appear after the next boundary

  atm_display_scanner #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dataIn     (dataIn),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [15:0] w, input int d);
    logic [3:0] n;
    n = w[4*d +: 4];
`ifdef ATM_DISP_LEAD_ZERO_BLANK_EN
    if (d > 0 && (w >> (4*d)) == 16'h0) return 7'h7F;
`endif
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // One running cycle: digit (k-1)/4 is lit after edge k, frame boundary at k%16==0.
  task automatic tick();
    int d;
    logic [3:0] ea;
    @(posedge clk); #1;
    k++;
    d  = ((k-1)/4) % 4;
    ea = ~(4'b0001 << d);
    chk("an", 32'(an), 32'(ea));
    chk("seg", 32'(seg), 32'(exp_seg(shown, d)));
    chk("frame_done", 32'(frame_done), 32'(k % 16 == 0));
    if (k % 16 == 0) shown = next_shown;
  endtask

  task automatic rtick();
    @(posedge clk); #1;
    chk("rst_an", 32'(an), 32'h0000000F);
    chk("rst_seg", 32'(seg), 32'h0000007F);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    k = 0;
    shown = 16'h0;
    next_shown = 16'h0;
  endtask

  task automatic load(input logic [15:0] v);
    logic on_boundary;
    on_boundary = (k % 16 == 15);
    en = 1'b1;
    dataIn = v;
    next_shown = v;
    tick();
    en = 1'b0;
    chk("load_pending", 32'(pending), on_boundary ? 32'h0 : 32'h1);
  endtask

  task automatic to_boundary();
    while (k % 16 != 0) tick();
    chk("commit_pending", 32'(pending), 32'h0);
  endtask

  initial begin
    // Reset held three cycles, then a full frame of zeros.
    rst = 1'b1;
    repeat (3) rtick();
    rst = 1'b0;
    repeat (16) tick();

    // Mid-frame load: display unchanged until boundary, then 4,3,2,1.
    repeat (2) tick();
    load(16'h1234);
    to_boundary();
    repeat (16) tick();

    // Two loads before the boundary: the last one wins.
    repeat (2) tick();
    load(16'h1111);
    load(16'h5678);
    to_boundary();
    repeat (16) tick();

    // Load exactly on the boundary cycle commits immediately.
    repeat (15) tick();
    load(16'h9999);
    repeat (16) tick();

    // Dash, zeros and blank code.
    repeat (3) tick();
    load(16'hA00B);
    to_boundary();
    repeat (16) tick();

    // Leading-zero patterns (literal unless blanking is built in).
    repeat (5) tick();
    load(16'h0042);
    to_boundary();
    repeat (16) tick();
    repeat (7) tick();
    load(16'h0000);
    to_boundary();
    repeat (16) tick();

    // Reset with a value pending: it must be discarded.
    repeat (5) tick();
    load(16'h8888);
    rst = 1'b1;
    rtick();
    rst = 1'b0;
    repeat (32) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_display_scanner.md
Name: atm_display_scanner

Overview:
- Reader side of the ATM's registered display data: takes a packed BCD word (amount or PIN mask) via a load strobe, and time-multiplexes it onto a common-anode 7-segment display.
- Sits between the ATM controller's output registers and the board display pins.
- Double-buffered, so a new value is only committed at a frame boundary and the display never tears.

Parameters:
- DIGITS, 4, number of displayed digits (>=2)
- REFRESH_DIV, 100000, clk cycles each digit is lit (>=2; set 4 in simulation)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  load strobe; samples dataIn this cycle
- dataIn  in  4*DIGITS  packed BCD, digit 0 = LSB nibble = rightmost
- an  out  DIGITS  anode enables, active-low, one-hot-low while running
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame_done  out  1  one-cycle pulse at each frame boundary
- pending  out  1  a loaded value is waiting for commit

Behaviour:
- Reset: all internal state is cleared on a rising clk with rst=1; rst overrides en.
  - an=all 1s, seg=7'h7F, frame_done=0, pending=0.
  - Refresh counter=0, digit index=0, display buffer=0, pending buffer=0.
  - Reset mid-frame discards the pending value.
- Refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances.
- Digit index wraps DIGITS-1 -> 0. That wrap is the frame boundary.
- Load (en=1, not a boundary cycle): dataIn is written to the pending buffer and pending=1 next cycle. Repeated en before the boundary overwrites it, so the last value wins.
- Frame boundary with pending=1 and en=0: pending buffer goes to the display buffer and pending clears.
- Frame boundary with en=1: dataIn goes straight to the display buffer, pending clears, and any older pending value is dropped.
- frame_done: asserted the cycle after each boundary, for exactly one cycle, regardless of load activity.
- Outputs are registered:
  - an/seg reflect the new digit index one cycle after it changes.
  - an drives exactly one 0 at a time after the first post-reset cycle.
- Decode:
  - nibbles 0-9: standard digits.
  - 0xA: dash (g only, seg=7'h3F).
  - 0xB-0xF: blank (7'h7F).
- Load-to-display latency: the committed value appears on seg one cycle after the next frame boundary. Worst case is DIGITS*REFRESH_DIV+2 cycles.
- No handshake back-pressure: en is always accepted.

Optional Feature:
- Macro ATM_DISP_LEAD_ZERO_BLANK_EN.
- Defined: digits above the most significant non-zero digit whose nibble is 0 display blank. Digit 0 is never blanked, so value 0 shows "0".
- Undefined: every digit is decoded literally, including leading zeros.

Decomposition:
- Package atm_disp_pkg holds:
  - constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F;
  - code constants DIG_DASH=4'hA, DIG_BLANK=4'hF;
  - the 10-entry segment pattern table.
- One combinational sub-module, bcd_to_seg (4-bit in, 7-bit out), instantiated once on the selected nibble.

Test Plan (DIGITS=4, REFRESH_DIV=4):
- Reset held 3 cycles, then released:
  - an=4'b1111 and seg=7'h7F during reset;
  - afterwards an cycles 1110,1101,1011,0111, each held 4 cycles;
  - seg=7'h40 ("0") throughout.
- en with dataIn=16'h1234 mid-frame:
  - pending=1 next cycle, displayed digits unchanged until the boundary;
  - after frame_done, digits 0..3 show 4,3,2,1 (seg 7'h19,7'h30,7'h24,7'h79).
- en 16'h1111 then en 16'h5678 before the boundary: only 5678 is ever displayed.
- en 16'h9999 exactly on the boundary cycle: committed immediately, pending stays 0, frame_done still pulses once.
- dataIn=16'hA00B: digit 3 shows 7'h3F, digit 0 blank.
  - With ATM_DISP_LEAD_ZERO_BLANK_EN, dataIn=16'h0042 shows blank, blank, 4, 2.
  - dataIn=16'h0000 shows "0" only in digit 0.
- rst asserted while pending=1: pending=0, display buffer=0 and outputs return to reset values next cycle.
